pyhdl_via_event_hub: RTL

- Multi-channel event collector that sits between HDL-side event sources and the Python-side VIA root listener.
- Accepts N independent valid/ready event streams and merges them by round-robin arbitration into one FIFO.
- Presents the FIFO head, tagged with its source channel, on a single valid/ready port that the listener drains.
- Generalises the single-listener registration to N channels with per-channel enable, buffering, backpressure and drop accounting.

---
 rtl/pyhdl_via_event_hub.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pyhdl_via_event_hub.sv
// Multi-channel event collector feeding the VIA root listener.
// N_CHANNELS valid/ready event streams are merged by round-robin arbitration into a
// DEPTH-entry FIFO whose head is presented first-word-fall-through on a single
// valid/ready port, tagged with the source channel.
//
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   chan_en                per-channel enable; a disabled channel is sunk and its events counted
//   ev_valid/ev_ready      per-channel event handshake
//   ev_data                channel i payload at [i*DATA_W +: DATA_W]
//   out_valid/out_ready    FIFO head handshake (pop on both high)
//   out_data, out_chan     head payload and source channel
//   out_ts                 head timestamp (only with PYHDL_IF_VIA_EVENT_TIMESTAMP_EN)
//   count                  FIFO occupancy
//   drop_count             saturating count of events discarded on disabled channels
//
// Optional feature: define PYHDL_IF_VIA_EVENT_TIMESTAMP_EN to stamp each entry with a
// free-running cycle counter and expose it on out_ts.
module pyhdl_via_event_hub #(
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TS_W       = 32,
  localparam int unsigned CHAN_W    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_CHANNELS-1:0]        chan_en,
  input  logic [N_CHANNELS-1:0]        ev_valid,
  output logic [N_CHANNELS-1:0]        ev_ready,
  input  logic [N_CHANNELS*DATA_W-1:0] ev_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [CHAN_W-1:0]            out_chan,
`ifdef PYHDL_IF_VIA_EVENT_TIMESTAMP_EN
  output logic [TS_W-1:0]              out_ts,
`endif
  output logic [CNT_W-1:0]             count,
  output logic [15:0]                  drop_count
);

  logic [CHAN_W-1:0] rr_last_q, rr_last_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       drop_count_q, drop_count_d;

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [CHAN_W-1:0] mem_chan_q [DEPTH];

  logic [N_CHANNELS-1:0] cand;
  logic [N_CHANNELS-1:0] cand_shift;
  logic [N_CHANNELS-1:0] grant_oh;
  logic                  grant_valid;
  logic [CHAN_W-1:0]     grant_idx;
  logic [DATA_W-1:0]     grant_data;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [16:0]           drop_sum;

  // Round-robin scan starting just after the last channel that actually pushed.
  always_comb begin
    int unsigned idx;
    cand        = ev_valid & chan_en;
    cand_shift  = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 1; k <= N_CHANNELS; k++) begin
      idx        = (32'(rr_last_q) + k) % N_CHANNELS;
      cand_shift = cand >> idx;
      if (!grant_valid && cand_shift[0]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[CHAN_W-1:0];
      end
    end
  end

  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    push       = grant_valid && !full;  // no bypass: a same-cycle pop does not free a slot
    pop        = (count_q != '0) && out_ready;
    grant_oh   = push ? (N_CHANNELS'(1) << grant_idx) : '0;
    ev_ready   = ~chan_en | grant_oh;
    grant_data = ev_data[32'(grant_idx) * DATA_W +: DATA_W];
  end

  always_comb begin
    rr_last_d = push ? grant_idx : rr_last_q;
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    drop_sum     = {1'b0, drop_count_q} + 17'($countones(ev_valid & ~chan_en));
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_last_q    <= CHAN_W'(N_CHANNELS - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_count_q <= '0;
    end else begin
      rr_last_q    <= rr_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_data_q[wr_ptr_q] <= grant_data;
      mem_chan_q[wr_ptr_q] <= grant_idx;
    end
  end

`ifdef PYHDL_IF_VIA_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] mem_ts_q [DEPTH];

  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_ts_q[wr_ptr_q] <= ts_q;
    end
  end

  assign out_ts = mem_ts_q[rd_ptr_q];
`endif

  assign out_valid  = (count_q != '0);
  assign out_data   = mem_data_q[rd_ptr_q];
  assign out_chan   = mem_chan_q[rd_ptr_q];
  assign count      = count_q;
  assign drop_count = drop_count_q;

endmodule
